cnn_stage_sequencer: RTL and testbench

- Top-level scheduler for the CNN inference pipeline: conv stage(s), then the fully-connected stage.
- On one `start` pulse, launches each stage in order with a one-cycle start pulse and waits for that stage's end indication.
- Latches the final male/female scores from the last stage, with a per-stage watchdog, abort and cycle accounting.
- Sits between the system control interface and the per-stage engines; only one stage is active at any time.

---
 rtl/cnn_stage_sequencer_if.sv | 42 ++++
 rtl/cnn_stage_sequencer.sv | 135 +++++++++++++
 tb/tb_cnn_stage_sequencer.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/cnn_stage_sequencer_if.sv
// cnn_stage_sequencer_if
//   Control/handshake bundle between the system controller, the per-stage
//   engines and the CNN stage sequencer.
//   master : controller/engine side (drives start, abort, stage_end, scores in)
//   slave  : sequencer side (drives stage_start, status, latched scores)
//   Signals:
//     start, abort            run request pulse / synchronous abort
//     stage_start[N-1:0]      one-hot single-cycle launch pulse per stage
//     stage_end[N-1:0]        per-stage end level
//     score_male_in/female_in 8-bit signed scores from the last stage
//     busy, cur_stage, done, error, score_male, score_female, is_male,
//     run_cycles              status and results
interface cnn_stage_sequencer_if #(
    parameter int NUM_STAGES = 3
);
    logic                  start;
    logic                  abort;
    logic [NUM_STAGES-1:0] stage_start;
    logic [NUM_STAGES-1:0] stage_end;
    logic [7:0]            score_male_in;
    logic [7:0]            score_female_in;
    logic                  busy;
    logic [2:0]            cur_stage;
    logic                  done;
    logic                  error;
    logic [7:0]            score_male;
    logic [7:0]            score_female;
    logic                  is_male;
    logic [31:0]           run_cycles;

    modport master (
        output start, abort, stage_end, score_male_in, score_female_in,
        input  stage_start, busy, cur_stage, done, error,
               score_male, score_female, is_male, run_cycles
    );

    modport slave (
        input  start, abort, stage_end, score_male_in, score_female_in,
        output stage_start, busy, cur_stage, done, error,
               score_male, score_female, is_male, run_cycles
    );
endinterface

// File: rtl/cnn_stage_sequencer.sv
// cnn_stage_sequencer
//   Launches NUM_STAGES pipeline stages in order (conv stages, then FC),
//   one at a time, waiting for each stage's end level. Latches the final
//   male/female scores, guards each stage with a watchdog, supports abort,
//   and counts busy cycles of the last run.
//   Ports:
//     clk     clock
//     rst     synchronous active-high reset
//     seq_if  cnn_stage_sequencer_if.slave (control, stage handshake, results)
module cnn_stage_sequencer #(
    parameter int NUM_STAGES  = 3,
    parameter int TIMEOUT_CYC = 200000
) (
    input  logic                         clk,
    input  logic                         rst,
    cnn_stage_sequencer_if.slave         seq_if
);
    typedef enum logic [2:0] {
        S_IDLE, S_LAUNCH, S_WAIT, S_GAP, S_FINISH, S_ERR
    } state_e;

    localparam logic [2:0]  LAST     = 3'(NUM_STAGES - 1);
    localparam logic [23:0] WD_LIMIT = 24'(TIMEOUT_CYC - 1);

    state_e                state_q, state_d;
    logic [2:0]            idx_q, idx_d;
    logic [23:0]           wd_q, wd_d;
    logic                  error_q, error_d;
    logic                  busy_q, busy_d;
    logic [7:0]            sm_q, sf_q;
    logic                  male_q;
    logic [31:0]           cyc_q;
    logic                  latch, clr;
    logic [NUM_STAGES-1:0] sel;
    logic                  end_cur;

    // One-hot of the active stage; used both to pick its end bit and to
    // drive its launch pulse, so other stages' end bits are never seen.
    always_comb begin
        sel = '0;
        for (int i = 0; i < NUM_STAGES; i++) sel[i] = (idx_q == 3'(i));
    end
    assign end_cur = |(seq_if.stage_end & sel);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        wd_d    = wd_q;
        error_d = error_q;
        latch   = 1'b0;
        clr     = 1'b0;
        case (state_q)
            S_IDLE: if (seq_if.start) begin
                state_d = S_LAUNCH;
                idx_d   = '0;
                error_d = 1'b0;
                clr     = 1'b1;
            end
            S_LAUNCH: begin
                state_d = S_WAIT;
                wd_d    = '0;
            end
            S_WAIT: begin
                wd_d = wd_q + 24'd1;
                // End beats a simultaneous watchdog expiry.
                if (end_cur) begin
                    state_d = (idx_q == LAST) ? S_FINISH : S_GAP;
                    latch   = (idx_q == LAST);
                end else if (wd_q == WD_LIMIT) begin
                    state_d = S_ERR;
                    error_d = 1'b1;
                end
            end
            S_GAP: begin
                idx_d   = idx_q + 3'd1;
                state_d = S_LAUNCH;
            end
            S_FINISH: state_d = S_IDLE;
            S_ERR:    state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
        // Abort overrides everything, including a start in IDLE.
        if (seq_if.abort) begin
            state_d = S_IDLE;
            idx_d   = idx_q;
            error_d = error_q;
            latch   = 1'b0;
            clr     = 1'b0;
        end
    end

    assign busy_d = (state_d == S_LAUNCH) || (state_d == S_WAIT) ||
                    (state_d == S_GAP)    || (state_d == S_FINISH);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            wd_q    <= '0;
            error_q <= 1'b0;
            busy_q  <= 1'b0;
            sm_q    <= '0;
            sf_q    <= '0;
            male_q  <= 1'b0;
            cyc_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            wd_q    <= wd_d;
            error_q <= error_d;
            busy_q  <= busy_d;
            // Counts edges after which the sequencer is still busy; the
            // accepting edge only clears.
            if (clr)
                cyc_q <= '0;
            else if (busy_d && cyc_q != '1)
                cyc_q <= cyc_q + 32'd1;
            if (latch) begin
                sm_q   <= seq_if.score_male_in;
                sf_q   <= seq_if.score_female_in;
                male_q <= $signed(seq_if.score_male_in) > $signed(seq_if.score_female_in);
            end
        end
    end

    assign seq_if.stage_start  = (state_q == S_LAUNCH) ? sel : '0;
    assign seq_if.busy         = busy_q;
    assign seq_if.cur_stage    = busy_q ? idx_q : 3'd0;
    assign seq_if.done         = (state_q == S_FINISH);
    assign seq_if.error        = error_q;
    assign seq_if.score_male   = sm_q;
    assign seq_if.score_female = sf_q;
    assign seq_if.is_male      = male_q;
    assign seq_if.run_cycles   = cyc_q;
endmodule

// File: tb/tb_cnn_stage_sequencer.sv
// tb_cnn_stage_sequencer
//   Directed bench for cnn_stage_sequencer: three instances (3 stages with a
//   long watchdog, 3 stages with TIMEOUT_CYC=8, 1 stage). All expected values
//   and cycle offsets are hand-derived; L is the launch cycle of stage 0.
module tb_cnn_stage_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk  = 0;
    int   n_fail = 0;
    logic bad;

    always #5 clk = ~clk;

    cnn_stage_sequencer_if #(.NUM_STAGES(3)) ifa ();
    cnn_stage_sequencer_if #(.NUM_STAGES(3)) ifw ();
    cnn_stage_sequencer_if #(.NUM_STAGES(1)) ifs ();

    cnn_stage_sequencer #(.NUM_STAGES(3), .TIMEOUT_CYC(200000)) dut_a (
        .clk(clk), .rst(rst), .seq_if(ifa));
    cnn_stage_sequencer #(.NUM_STAGES(3), .TIMEOUT_CYC(8)) dut_w (
        .clk(clk), .rst(rst), .seq_if(ifw));
    cnn_stage_sequencer #(.NUM_STAGES(1), .TIMEOUT_CYC(8)) dut_s (
        .clk(clk), .rst(rst), .seq_if(ifs));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Stage k on instance A answers lat cycles after its launch cycle.
    task automatic end_a(input int k, input int lat);
        repeat (lat) tick();
        ifa.stage_end[k] = 1'b1;
        tick();
        ifa.stage_end[k] = 1'b0;
    endtask

    initial begin
        ifa.start = 0; ifa.abort = 0; ifa.stage_end = '0;
        ifa.score_male_in = '0; ifa.score_female_in = '0;
        ifw.start = 0; ifw.abort = 0; ifw.stage_end = '0;
        ifw.score_male_in = '0; ifw.score_female_in = '0;
        ifs.start = 0; ifs.abort = 0; ifs.stage_end = '0;
        ifs.score_male_in = '0; ifs.score_female_in = '0;
        repeat (3) tick();
        rst = 1'b0;

        // Reset state
        chk("rst_busy", ifa.busy, 0);
        chk("rst_ss", ifa.stage_start, 0);
        chk("rst_cur", ifa.cur_stage, 0);
        chk("rst_done", ifa.done, 0);
        chk("rst_err", ifa.error, 0);
        chk("rst_rc", ifa.run_cycles, 0);
        chk("rst_w_err", ifw.error, 0);
        tick();

        // Nominal run: latencies 50/30/20, scores 0x15 / 0xF0
        ifa.start = 1; tick(); ifa.start = 0;
        chk("nom_l0", ifa.stage_start, 3'b001);
        chk("nom_busy", ifa.busy, 1);
        end_a(0, 50);
        chk("nom_gap_ss", ifa.stage_start, 0);
        tick();
        chk("nom_l1", ifa.stage_start, 3'b010);
        chk("nom_cur1", ifa.cur_stage, 1);
        end_a(1, 30);
        tick();
        chk("nom_l2", ifa.stage_start, 3'b100);
        ifa.score_male_in = 8'h15; ifa.score_female_in = 8'hF0;
        end_a(2, 20);
        chk("nom_done", ifa.done, 1);
        chk("nom_sm", ifa.score_male, 8'h15);
        chk("nom_sf", ifa.score_female, 8'hF0);
        chk("nom_male", ifa.is_male, 1);
        chk("nom_rc", ifa.run_cycles, 105);
        tick();
        chk("nom_done_off", ifa.done, 0);
        chk("nom_idle", ifa.busy, 0);
        chk("nom_rc_hold", ifa.run_cycles, 105);

        // Spurious end of a non-active stage, early end held through LAUNCH
        ifa.start = 1; tick(); ifa.start = 0;
        chk("sp_l0", ifa.stage_start, 3'b001);
        repeat (5) tick();
        ifa.stage_end[2] = 1; tick(); ifa.stage_end[2] = 0;
        chk("sp_cur0", ifa.cur_stage, 0);
        chk("sp_busy", ifa.busy, 1);
        tick();
        chk("sp_no_l1", ifa.stage_start, 0);
        end_a(0, 3);
        ifa.stage_end[1] = 1; tick();
        chk("sp_l1", ifa.stage_start, 3'b010);
        tick();
        ifa.stage_end[1] = 0;
        tick();
        chk("sp_no_l2", ifa.stage_start, 0);
        tick();
        chk("sp_cur1", ifa.cur_stage, 1);
        end_a(1, 3);
        tick();
        chk("sp_l2", ifa.stage_start, 3'b100);
        ifa.score_male_in = 8'h80; ifa.score_female_in = 8'h01;
        end_a(2, 2);
        chk("sp_done", ifa.done, 1);
        chk("sp_sm", ifa.score_male, 8'h80);
        chk("sp_male_signed", ifa.is_male, 0);
        tick();

        // Abort during stage 1 WAIT
        ifa.start = 1; tick(); ifa.start = 0;
        end_a(0, 3);
        tick();
        chk("ab_l1", ifa.stage_start, 3'b010);
        repeat (4) tick();
        chk("ab_rc_pre", ifa.run_cycles, 9);
        ifa.abort = 1; tick(); ifa.abort = 0;
        chk("ab_busy", ifa.busy, 0);
        chk("ab_cur", ifa.cur_stage, 0);
        chk("ab_done", ifa.done, 0);
        chk("ab_rc", ifa.run_cycles, 9);
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (ifa.stage_start != 0 || ifa.done || ifa.busy) bad = 1;
        end
        chk("ab_quiet", bad, 0);
        chk("ab_rc_frozen", ifa.run_cycles, 9);
        chk("ab_sm_hold", ifa.score_male, 8'h80);
        chk("ab_sf_hold", ifa.score_female, 8'h01);

        // Restart from stage 0 with start pulsed while busy, tie scores
        ifa.start = 1; tick(); ifa.start = 0;
        chk("rs_l0", ifa.stage_start, 3'b001);
        repeat (2) tick();
        ifa.start = 1; tick(); ifa.start = 0;
        end_a(0, 2);
        ifa.start = 1; tick(); ifa.start = 0;
        chk("rs_l1", ifa.stage_start, 3'b010);
        end_a(1, 2);
        tick();
        chk("rs_l2", ifa.stage_start, 3'b100);
        ifa.score_male_in = 8'h40; ifa.score_female_in = 8'h40;
        ifa.start = 1; tick(); ifa.start = 0;
        end_a(2, 1);
        chk("rs_done", ifa.done, 1);
        chk("rs_tie", ifa.is_male, 0);
        chk("rs_sm", ifa.score_male, 8'h40);
        chk("rs_rc", ifa.run_cycles, 14);
        ifa.start = 1; tick(); ifa.start = 0;
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            if (ifa.stage_start != 0 || ifa.busy) bad = 1;
            tick();
        end
        chk("rs_single_run", bad, 0);

        // Abort together with start in IDLE drops the start
        ifa.abort = 1; ifa.start = 1; tick(); ifa.abort = 0; ifa.start = 0;
        chk("abst_ss", ifa.stage_start, 0);
        chk("abst_busy", ifa.busy, 0);
        tick();
        chk("abst_busy2", ifa.busy, 0);

        // Reset during stage 2 WAIT, then a fresh run
        ifa.start = 1; tick(); ifa.start = 0;
        end_a(0, 2);
        tick();
        end_a(1, 2);
        tick();
        chk("rr_l2", ifa.stage_start, 3'b100);
        repeat (3) tick();
        rst = 1; tick(); rst = 0;
        chk("rr_ss", ifa.stage_start, 0);
        chk("rr_busy", ifa.busy, 0);
        chk("rr_cur", ifa.cur_stage, 0);
        chk("rr_done", ifa.done, 0);
        chk("rr_err", ifa.error, 0);
        chk("rr_sm", ifa.score_male, 0);
        chk("rr_sf", ifa.score_female, 0);
        chk("rr_male", ifa.is_male, 0);
        chk("rr_rc", ifa.run_cycles, 0);
        tick();
        ifa.start = 1; tick(); ifa.start = 0;
        chk("rr2_l0", ifa.stage_start, 3'b001);
        end_a(0, 2);
        tick();
        chk("rr2_l1", ifa.stage_start, 3'b010);
        end_a(1, 2);
        tick();
        chk("rr2_l2", ifa.stage_start, 3'b100);
        ifa.score_male_in = 8'h7F; ifa.score_female_in = 8'h80;
        end_a(2, 2);
        chk("rr2_done", ifa.done, 1);
        chk("rr2_male", ifa.is_male, 1);
        chk("rr2_rc", ifa.run_cycles, 11);
        tick();

        // Watchdog instance: end on the expiry edge wins, then a real timeout
        ifw.start = 1; tick(); ifw.start = 0;
        chk("wd_l0", ifw.stage_start, 3'b001);
        repeat (8) tick();
        ifw.stage_end[0] = 1; tick(); ifw.stage_end[0] = 0;
        chk("wd_tie_err", ifw.error, 0);
        chk("wd_tie_busy", ifw.busy, 1);
        tick();
        chk("wd_l1", ifw.stage_start, 3'b010);
        repeat (2) tick();
        ifw.stage_end[1] = 1; tick(); ifw.stage_end[1] = 0;
        tick();
        chk("wd_l2", ifw.stage_start, 3'b100);
        repeat (2) tick();
        ifw.score_male_in = 8'h11; ifw.score_female_in = 8'h22;
        ifw.stage_end[2] = 1; tick(); ifw.stage_end[2] = 0;
        chk("wd_done1", ifw.done, 1);
        tick();
        ifw.start = 1; tick(); ifw.start = 0;
        repeat (2) tick();
        ifw.stage_end[0] = 1; tick(); ifw.stage_end[0] = 0;
        tick();
        chk("wd2_l1", ifw.stage_start, 3'b010);
        repeat (8) tick();
        chk("wd2_pre_err", ifw.error, 0);
        chk("wd2_pre_busy", ifw.busy, 1);
        tick();
        chk("wd2_err", ifw.error, 1);
        chk("wd2_busy", ifw.busy, 0);
        chk("wd2_done", ifw.done, 0);
        chk("wd2_sm", ifw.score_male, 8'h11);
        chk("wd2_sf", ifw.score_female, 8'h22);
        tick();
        chk("wd2_sticky", ifw.error, 1);
        chk("wd2_ss", ifw.stage_start, 0);
        ifw.start = 1; tick(); ifw.start = 0;
        chk("wd3_clr", ifw.error, 0);
        chk("wd3_l0", ifw.stage_start, 3'b001);
        ifw.abort = 1; tick(); ifw.abort = 0;
        chk("wd3_abort", ifw.busy, 0);

        // Single-stage instance: no GAP
        ifs.start = 1; tick(); ifs.start = 0;
        chk("s1_l0", ifs.stage_start, 1);
        repeat (3) tick();
        ifs.score_male_in = 8'hFF; ifs.score_female_in = 8'hFE;
        ifs.stage_end[0] = 1; tick(); ifs.stage_end[0] = 0;
        chk("s1_done", ifs.done, 1);
        chk("s1_sm", ifs.score_male, 8'hFF);
        chk("s1_male", ifs.is_male, 1);
        chk("s1_rc", ifs.run_cycles, 4);
        tick();
        chk("s1_idle", ifs.busy, 0);
        chk("s1_ss", ifs.stage_start, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
